// File: rtl/la_pkg.sv
// Shared types and constants for the command/response front end.
// The opcode field positions are shared with cmd_cfg.
package la_pkg;

  localparam int unsigned CMD_W   = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 14;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HIGH = 2'd1,
    RX_FULL = 2'd2
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  function automatic logic [OPC_W-1:0] cmd_opcode(input logic [CMD_W-1:0] c);
    return c[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cmd_assembler_if.sv
// UART-side and cmd_cfg-side signals of the command assembler.
// slave is the assembler; master is whoever surrounds it.
interface cmd_assembler_if;

  logic                        rx_rdy;
  logic [la_pkg::BYTE_W-1:0]   rx_data;
  logic                        clr_rx_rdy;
  logic [la_pkg::CMD_W-1:0]    cmd;
  logic                        cmd_rdy;
  logic                        frame_err;
  logic                        send_resp;
  logic [la_pkg::BYTE_W-1:0]   resp;
  logic                        trmt;
  logic [la_pkg::BYTE_W-1:0]   tx_data;
  logic                        tx_done;
  logic                        resp_sent;

  modport slave (
    input  rx_rdy, rx_data, send_resp, resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, frame_err, trmt, tx_data, resp_sent
  );

  modport master (
    output rx_rdy, rx_data, send_resp, resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, frame_err, trmt, tx_data, resp_sent
  );

endinterface

// File: rtl/byte_timeout_ctr.sv
// Saturating up-counter with synchronous clear and enable.
// tc_c flags that the count has reached MAX.
module byte_timeout_ctr #(
  parameter int unsigned MAX = 65535,
  parameter int unsigned W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != W'(MAX)))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_c = (cnt_q == W'(MAX));

endmodule

// File: rtl/cmd_assembler.sv
// Frames two UART bytes into a 16-bit command for cmd_cfg and
// forwards cmd_cfg's response byte to the UART transmitter.
module cmd_assembler
  import la_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned TO_W    = 16
) (
  input  logic            clk,
  input  logic            clr_cmd_rdy,
  cmd_assembler_if.slave  bus
);

  rx_state_e             rx_state_q, rx_state_d;
  logic [CMD_W-1:0]      cmd_q, cmd_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  to_clr, to_en, to_tc;

  tx_state_e             tx_state_q, tx_state_d;
  logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
  logic                  trmt_q, trmt_d;
  logic                  resp_sent_q, resp_sent_d;

  byte_timeout_ctr #(
    .MAX (TIMEOUT),
    .W   (TO_W)
  ) u_to_ctr (
    .clk  (clk),
    .rst  (clr_cmd_rdy),
    .clr  (to_clr),
    .en   (to_en),
    .tc_c (to_tc)
  );

  // RX framing: a byte arriving on the terminal-count cycle still completes the frame
  always_comb begin
    rx_state_d  = rx_state_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    frame_err_d = 1'b0;
    to_clr      = 1'b0;
    to_en       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (bus.rx_rdy) begin
          cmd_d[CMD_W-1:BYTE_W] = bus.rx_data;
          to_clr                = 1'b1;
          rx_state_d            = RX_HIGH;
        end
      end
      RX_HIGH: begin
        if (bus.rx_rdy) begin
          cmd_d[BYTE_W-1:0] = bus.rx_data;
          cmd_rdy_d         = 1'b1;
          rx_state_d        = RX_FULL;
        end else if (to_tc) begin
          frame_err_d = 1'b1;
          rx_state_d  = RX_IDLE;
        end else begin
          to_en = 1'b1;
        end
      end
      RX_FULL: begin
        rx_state_d = RX_FULL;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX handshake: send_resp while busy and tx_done while idle are dropped
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_data_d  = bus.resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr_cmd_rdy) begin
    if (clr_cmd_rdy) begin
      rx_state_q  <= RX_IDLE;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // Holding off clr_rx_rdy while FULL back-pressures the UART
  assign bus.clr_rx_rdy = bus.rx_rdy & (rx_state_q != RX_FULL);
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Bench for cmd_assembler: directed scenarios then random traffic,
// every cycle compared against a byte-level reference model.
module tb_cmd_assembler;
  import la_pkg::*;

  localparam int unsigned TO = 20;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic clr_cmd_rdy;

  cmd_assembler_if bus ();

  cmd_assembler #(.TIMEOUT(TO), .TO_W(TW)) dut (
    .clk         (clk),
    .clr_cmd_rdy (clr_cmd_rdy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes of the partial frame, silence since the high byte
  logic [7:0]  pend[$];
  int          m_silent;
  logic [15:0] m_cmd;
  logic        m_cmd_rdy, m_frame_err;
  logic        m_tx_busy, m_trmt, m_resp_sent;
  logic [7:0]  m_tx_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_silent    = 0;
    m_cmd       = 16'h0000;
    m_cmd_rdy   = 1'b0;
    m_frame_err = 1'b0;
    m_tx_busy   = 1'b0;
    m_trmt      = 1'b0;
    m_resp_sent = 1'b0;
    m_tx_data   = 8'h00;
  endtask

  task automatic model_step();
    m_frame_err = 1'b0;
    if (!m_cmd_rdy) begin
      if (pend.size() == 1) begin
        if (bus.rx_rdy) begin
          m_cmd     = {pend[0], bus.rx_data};
          m_cmd_rdy = 1'b1;
          pend.delete();
        end else if (m_silent >= int'(TO)) begin
          m_frame_err = 1'b1;
          pend.delete();
        end else begin
          m_silent++;
        end
      end else if (bus.rx_rdy) begin
        pend.push_back(bus.rx_data);
        m_cmd[15:8] = bus.rx_data;
        m_silent    = 0;
      end
    end
    m_trmt      = 1'b0;
    m_resp_sent = 1'b0;
    if (!m_tx_busy) begin
      if (bus.send_resp) begin
        m_tx_data = bus.resp;
        m_trmt    = 1'b1;
        m_tx_busy = 1'b1;
      end
    end else if (bus.tx_done) begin
      m_resp_sent = 1'b1;
      m_tx_busy   = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("cmd",       32'(bus.cmd),       32'(m_cmd));
    check_eq("cmd_rdy",   32'(bus.cmd_rdy),   32'(m_cmd_rdy));
    check_eq("frame_err", 32'(bus.frame_err), 32'(m_frame_err));
    check_eq("trmt",      32'(bus.trmt),      32'(m_trmt));
    check_eq("tx_data",   32'(bus.tx_data),   32'(m_tx_data));
    check_eq("resp_sent", 32'(bus.resp_sent), 32'(m_resp_sent));
  endtask

  // One clock: check combinational consume, step model, then check registers
  task automatic cycle();
    #1;
    check_eq("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(bus.rx_rdy && !m_cmd_rdy));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive(input logic rr, input logic [7:0] rd, input logic sr,
                       input logic [7:0] rs, input logic td);
    bus.rx_rdy    = rr;
    bus.rx_data   = rd;
    bus.send_resp = sr;
    bus.resp      = rs;
    bus.tx_done   = td;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    cycle();
    bus.rx_rdy  = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    #2 clr_cmd_rdy = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(bus.rx_rdy));
    #2 clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    clr_cmd_rdy = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check_eq("rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
    #2 clr_cmd_rdy = 1'b0;

    // Normal frame, bytes 10 cycles apart
    send_byte(8'h4B);
    cycles(9);
    send_byte(8'h55);
    check_eq("normal_cmd", 32'(bus.cmd), 32'h4B55);
    cycles(3);
    pulse_reset();

    // Timeout then a fresh frame
    send_byte(8'h0B);
    cycles(TO + 4);
    send_byte(8'h81);
    send_byte(8'h00);
    check_eq("after_to_cmd", 32'(bus.cmd), 32'h8100);
    cycles(2);
    pulse_reset();

    // Low byte exactly on the terminal-count cycle
    send_byte(8'h12);
    cycles(TO);
    send_byte(8'h34);
    check_eq("race_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    cycles(2);

    // Back-pressure while FULL, then reset with the byte still pending
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'hA5;
    cycles(3);
    pulse_reset();
    cycle();
    bus.rx_rdy = 1'b0;
    cycles(2);

    // Response path with an ignored send_resp while busy
    drive(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    cycle();
    bus.send_resp = 1'b0;
    cycles(10);
    drive(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0);
    cycle();
    bus.send_resp = 1'b0;
    cycles(38);
    bus.tx_done = 1'b1;
    cycle();
    bus.tx_done = 1'b0;
    cycles(3);

    // Reset between high and low byte
    send_byte(8'hC3);
    cycles(3);
    pulse_reset();
    send_byte(8'h3C);
    send_byte(8'h99);
    check_eq("mid_rst_cmd", 32'(bus.cmd), 32'h3C99);
    cycles(2);
    pulse_reset();

    // Random traffic with varying byte density to provoke timeouts
    begin
      int rx_pct = 30;
      for (int i = 0; i < 4000; i++) begin
        if ((i % 64) == 0) begin
          case ($urandom_range(0, 2))
            0:       rx_pct = 2;
            1:       rx_pct = 10;
            default: rx_pct = 50;
          endcase
        end
        drive(($urandom_range(0, 99) < rx_pct), 8'($urandom),
              ($urandom_range(0, 99) < 10), 8'($urandom),
              ($urandom_range(0, 99) < 6));
        if ($urandom_range(0, 149) == 0) pulse_reset();
        else cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
